// File: rtl/decode_issue_ctrl_if.sv
// Purpose: bundles the fetch, decoder, execute, writeback and status signals
//          of the decode/issue controller.
// Modports:
//   master - the controller: takes the fetch offer, decoder fields, execute
//            ready, writeback and flush; drives if_ready, dec_instr, ex_valid,
//            ex_instr_bus, busy_mask and stall_cnt.
//   slave  - the surrounding core (fetch, decoder, execute, writeback).
// Parameter: STALL_W - width of the stall counter, must match the controller.
interface decode_issue_ctrl_if #(
    parameter int unsigned STALL_W = 16
) ();
    logic               if_valid;
    logic [31:0]        if_instr;
    logic               if_ready;
    logic [31:0]        dec_instr;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic [4:0]         dec_rd;
    logic               dec_rs1_valid;
    logic               dec_rs2_valid;
    logic               dec_rd_valid;
    logic [36:0]        dec_instr_bus;
    logic               ex_valid;
    logic [36:0]        ex_instr_bus;
    logic               ex_ready;
    logic               wb_valid;
    logic [4:0]         wb_rd;
    logic               flush;
    logic [31:0]        busy_mask;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        input  if_valid, if_instr,
        output if_ready, dec_instr,
        input  dec_rs1, dec_rs2, dec_rd,
        input  dec_rs1_valid, dec_rs2_valid, dec_rd_valid, dec_instr_bus,
        output ex_valid, ex_instr_bus,
        input  ex_ready,
        input  wb_valid, wb_rd, flush,
        output busy_mask, stall_cnt
    );

    modport slave (
        output if_valid, if_instr,
        input  if_ready, dec_instr,
        output dec_rs1, dec_rs2, dec_rd,
        output dec_rs1_valid, dec_rs2_valid, dec_rd_valid, dec_instr_bus,
        input  ex_valid, ex_instr_bus,
        output ex_ready,
        output wb_valid, wb_rd, flush,
        input  busy_mask, stall_cnt
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Purpose: multi-cycle sequencer between fetch and execute. Accepts one
//          instruction, holds it on dec_instr for DEC_LAT cycles while the
//          decoder works, checks the decoded register fields against a
//          32-entry write-pending scoreboard, then offers the decoded bus to
//          execute. Scoreboard bits are set at issue and cleared by writeback.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - decode_issue_ctrl_if.master (fetch/decoder/execute/writeback/status)
// Parameters:
//   DEC_LAT - decoder latency in cycles, 0..3 (0 = combinational decoder)
//   STALL_W - width of the saturating hazard-stall counter
// Build option:
//   WB_BYPASS_EN - when defined, the hazard check ignores the busy bit being
//                  cleared by writeback in the same cycle.
module decode_issue_ctrl #(
    parameter int unsigned DEC_LAT = 1,
    parameter int unsigned STALL_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    decode_issue_ctrl_if.master bus
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned BUS_W   = 37;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned NREG    = 32;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEC   = 2'd1,
        CHECK = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   lat_cnt_next;

    logic [INSTR_W-1:0] dec_instr_q;
    logic [BUS_W-1:0]   ex_bus_q;
    logic               ex_valid_q;
    logic [REG_W-1:0]   iss_rd_q;
    logic               iss_rd_valid_q;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_next;
    logic [NREG-1:0]    busy_chk;
    logic [NREG-1:0]    wb_clr;
    logic [NREG-1:0]    iss_set;
    logic [STALL_W-1:0] stall_q;

    logic               accept;
    logic               pass;
    logic               issue_fire;
    logic               hazard;

    // Fetch may only hand over an instruction while idle and not being flushed.
    assign bus.if_ready     = (state == IDLE) && !bus.flush;
    assign bus.dec_instr    = dec_instr_q;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_instr_bus = ex_bus_q;
    assign bus.busy_mask    = busy_q;
    assign bus.stall_cnt    = stall_q;

    // One-hot of the register retired by writeback this cycle.
    always_comb begin
        wb_clr = '0;
        if (bus.wb_valid) begin
            wb_clr = NREG'(1) << bus.wb_rd;
        end
    end

    // Scoreboard view used by the hazard check.
    always_comb begin
`ifdef WB_BYPASS_EN
        busy_chk = busy_q & ~wb_clr;
`else
        busy_chk = busy_q;
`endif
    end

    always_comb begin
        hazard = (bus.dec_rs1_valid && busy_chk[bus.dec_rs1])
              || (bus.dec_rs2_valid && busy_chk[bus.dec_rs2])
              || (bus.dec_rd_valid  && busy_chk[bus.dec_rd]);
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        accept       = 1'b0;
        pass         = 1'b0;
        issue_fire   = 1'b0;
        if (bus.flush) begin
            state_next   = IDLE;
            lat_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_valid) begin
                        accept = 1'b1;
                        if (DEC_LAT == 32'd0) begin
                            state_next = CHECK;
                        end else begin
                            state_next   = DEC;
                            lat_cnt_next = CNT_W'(DEC_LAT);
                        end
                    end
                end
                DEC: begin
                    // Counter is loaded with DEC_LAT, so DEC lasts exactly DEC_LAT cycles.
                    lat_cnt_next = lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) begin
                        pass       = 1'b1;
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.ex_ready) begin
                        issue_fire = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Scoreboard update: writeback clears, issue sets (set wins), x0 never busy.
    always_comb begin
        iss_set = '0;
        if (issue_fire && iss_rd_valid_q && (iss_rd_q != '0)) begin
            iss_set = NREG'(1) << iss_rd_q;
        end
        busy_next    = (busy_q & ~wb_clr) | iss_set;
        busy_next[0] = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_instr_q    <= '0;
            ex_bus_q       <= '0;
            ex_valid_q     <= 1'b0;
            iss_rd_q       <= '0;
            iss_rd_valid_q <= 1'b0;
            busy_q         <= '0;
            stall_q        <= '0;
        end else begin
            if (accept) begin
                dec_instr_q <= bus.if_instr;
            end
            // rd is captured with the bus so the scoreboard set does not depend
            // on the decoder outputs staying valid during ISSUE.
            if (pass) begin
                ex_bus_q       <= bus.dec_instr_bus;
                iss_rd_q       <= bus.dec_rd;
                iss_rd_valid_q <= bus.dec_rd_valid;
            end
            ex_valid_q <= (state_next == ISSUE);
            busy_q     <= busy_next;
            if ((state == CHECK) && hazard && (stall_q != {STALL_W{1'b1}})) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Purpose: directed bench for decode_issue_ctrl (DEC_LAT=1). A small decoder
//          model answers dec_instr; stimulus pushes the expected ex_instr_bus
//          of every instruction that should reach execute, and a monitor pops
//          and compares on each accepted issue. Cycle-exact status checks are
//          made inline by the stimulus.
module tb_decode_issue_ctrl;

    localparam int unsigned STALL_W = 16;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    decode_issue_ctrl_if #(.STALL_W(STALL_W)) bus ();

    decode_issue_ctrl #(
        .DEC_LAT(1),
        .STALL_W(STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks;
    int errors;
    int mon_checks;
    int mon_errors;
    logic [36:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: R-type uses rs1/rs2/rd, OP-IMM uses rs1/rd.
    always_comb begin
        logic [6:0] op;
        op = bus.dec_instr[6:0];
        bus.dec_rd        = bus.dec_instr[11:7];
        bus.dec_rs1       = bus.dec_instr[19:15];
        bus.dec_rs2       = bus.dec_instr[24:20];
        bus.dec_rs1_valid = (op == 7'b0110011) || (op == 7'b0010011);
        bus.dec_rs2_valid = (op == 7'b0110011);
        bus.dec_rd_valid  = (op == 7'b0110011) || (op == 7'b0010011);
        bus.dec_instr_bus = {bus.dec_instr[6:2], bus.dec_instr};
    end

    // Scoreboard monitor: every accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready && !bus.flush) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL issue_unexpected: got ex_instr_bus=%h with empty queue", bus.ex_instr_bus);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if (bus.ex_instr_bus !== e) begin
                    mon_errors++;
                    $display("FAIL issue_bus: got %h expected %h", bus.ex_instr_bus, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_if_ready"},  64'(bus.if_ready), 64'd1);
        chk({tag, "_dec_instr"}, 64'(bus.dec_instr), 64'd0);
        chk({tag, "_ex_valid"},  64'(bus.ex_valid), 64'd0);
        chk({tag, "_ex_bus"},    64'(bus.ex_instr_bus), 64'd0);
        chk({tag, "_busy"},      64'(bus.busy_mask), 64'd0);
        chk({tag, "_stall"},     64'(bus.stall_cnt), 64'd0);
    endtask

    task automatic offer(input logic [31:0] instr);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
    endtask

    initial begin
        checks = 0; errors = 0; mon_checks = 0; mon_errors = 0;
        rst = 1'b1;
        bus.if_valid = 1'b0; bus.if_instr = '0;
        bus.ex_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        step();
        rst = 1'b0;

        // 1: add x1,x1,x2 -> ex_valid in cycle 3, busy[1] set after issue
        offer(32'h002080b3);
        exp_q.push_back(37'h0c002080b3);
        step();
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("t1_dec_instr", 64'(bus.dec_instr), 64'h002080b3);
        chk("t1_ex_valid_c1", 64'(bus.ex_valid), 64'd0);
        step();
        step();
        @(negedge clk);
        chk("t1_ex_valid_c3", 64'(bus.ex_valid), 64'd1);
        step();
        @(negedge clk);
        chk("t1_busy", 64'(bus.busy_mask), 64'h2);
        chk("t1_ex_valid_drop", 64'(bus.ex_valid), 64'd0);

        // 2: addi x1,x1,1 stalls on x1 until writeback
        offer(32'h00108093);
        exp_q.push_back(37'h0400108093);
        step();
        bus.if_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t2_stall1", 64'(bus.stall_cnt), 64'd1);
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd1;
        @(negedge clk);
        chk("t2_stall2", 64'(bus.stall_cnt), 64'd2);
        chk("t2_no_issue", 64'(bus.ex_valid), 64'd0);
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_ex_valid_wb1", 64'(bus.ex_valid), 64'(BYP));
        step();
        @(negedge clk);
        chk("t2_ex_valid_wb2", 64'(bus.ex_valid), 64'(!BYP));
        step();
        @(negedge clk);
        chk("t2_busy", 64'(bus.busy_mask), 64'h2);
        chk("t2_stall_final", 64'(bus.stall_cnt), BYP ? 64'd2 : 64'd3);

        // 3: addi x5,x7,-1 held 4 cycles by ex_ready=0
        bus.ex_ready = 1'b0;
        offer(32'hfff38293);
        exp_q.push_back(37'h04fff38293);
        step();
        bus.if_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(bus.ex_valid), 64'd1);
            chk("t3_hold_bus", 64'(bus.ex_instr_bus), 64'h04fff38293);
            chk("t3_hold_busy", 64'(bus.busy_mask), 64'h2);
            step();
        end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("t3_busy_before_edge", 64'(bus.busy_mask), 64'h2);
        step();
        @(negedge clk);
        chk("t3_busy", 64'(bus.busy_mask), 64'h22);
        chk("t3_ex_valid_drop", 64'(bus.ex_valid), 64'd0);

        // 4: rd=x0 issue and wb to x0 leave the scoreboard alone
        offer(32'h00000013);
        exp_q.push_back(37'h0400000013);
        step();
        bus.if_valid = 1'b0;
        step();
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd0;
        @(negedge clk);
        chk("t4_ex_valid", 64'(bus.ex_valid), 64'd1);
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t4_busy", 64'(bus.busy_mask), 64'h22);

        // 5: flush in ISSUE beats ex_ready
        offer(32'h00500313);
        step();
        bus.if_valid = 1'b0;
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t5_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("t5_if_ready", 64'(bus.if_ready), 64'd1);
        chk("t5_busy", 64'(bus.busy_mask), 64'h22);

        // 6: issue set of x3 and wb of x3 in the same cycle -> set wins
        offer(32'h00100193);
        exp_q.push_back(37'h0400100193);
        step();
        bus.if_valid = 1'b0;
        step();
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd3;
        @(negedge clk);
        chk("t6_ex_valid", 64'(bus.ex_valid), 64'd1);
        step();
        bus.wb_rd = 5'd5;
        @(negedge clk);
        chk("t6_busy_set_wins", 64'(bus.busy_mask), 64'h2a);
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_wb_clear", 64'(bus.busy_mask), 64'h0a);

        // Async reset while in DEC
        offer(32'h00000013);
        step();
        bus.if_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
